// File: rtl/sqrt_cordic_rr_scheduler_pkg.sv
// Shared types and sizing helpers for the round-robin sqrt CORDIC scheduler.
package sqrt_sched_pkg;

    // IEEE-754 single precision operand/result width
    localparam int FLOAT_W = 32;

    // Default configuration of the scheduler
    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

    // Width of an index/counter able to hold values 0..n-1 (at least 1 bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Owner index and watchdog counter widths for the default configuration
    localparam int OWNER_W_DEF = idx_w(N_REQ_DEF);
    localparam int WDOG_W_DEF  = idx_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/sqrt_cordic_rr_scheduler_if.sv
// Client-side request/response bus and sqrt-unit handshake bus.

// Requesters drive req/req_data (master); the scheduler answers (slave).
interface sqrt_cordic_rr_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int FLOAT_W = sqrt_sched_pkg::FLOAT_W
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*FLOAT_W-1:0] req_data;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_valid;
    logic [FLOAT_W-1:0]       rsp_data;
    logic                     rsp_neg;
    logic                     rsp_timeout;

    modport master (
        output req, req_data,
        input  gnt, rsp_valid, rsp_data, rsp_neg, rsp_timeout
    );

    modport slave (
        input  req, req_data,
        output gnt, rsp_valid, rsp_data, rsp_neg, rsp_timeout
    );
endinterface

// The scheduler controls the shared sqrt unit (master); the unit is the slave.
interface sqrt_unit_if #(
    parameter int FLOAT_W = sqrt_sched_pkg::FLOAT_W
);
    logic               sq_rst;
    logic               sq_start;
    logic [FLOAT_W-1:0] sq_operand;
    logic               sq_done;
    logic               sq_neg;
    logic [FLOAT_W-1:0] sq_result;

    modport master (
        output sq_rst, sq_start, sq_operand,
        input  sq_done, sq_neg, sq_result
    );

    modport slave (
        input  sq_rst, sq_start, sq_operand,
        output sq_done, sq_neg, sq_result
    );
endinterface

// File: rtl/sqrt_cordic_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: finds the first pending request at or after the
// pointer; the pointer moves past the served requester when enabled.
module rr_arbiter
    import sqrt_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    output logic             win_any,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] ptr_q;

    // Winner search: scan N_REQ positions starting at the pointer
    always_comb begin
        int unsigned pos;
        win_any = 1'b0;
        win_idx = '0;
        pos     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr_q) + k) % N_REQ;
            if (!win_any && req[pos[IDX_W-1:0]]) begin
                win_any = 1'b1;
                win_idx = pos[IDX_W-1:0];
            end
        end
    end

    // Pointer register: one past the requester just granted, wrapping at N_REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (upd_en) begin
            if (32'(upd_idx) == 32'(N_REQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= upd_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sqrt_cordic_rr_scheduler.sv
// Shares one sqrt CORDIC unit between N_REQ requesters: round-robin grant,
// operand latch, start/done handshake, result routing and a done watchdog.
module sqrt_cordic_rr_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sqrt_cordic_rr_scheduler_if.slave  cli,
    sqrt_unit_if.master                sq
);

    localparam int              OWN_W   = idx_w(N_REQ);
    localparam int              WD_W    = idx_w(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;

    logic             win_any;
    logic [OWN_W-1:0] win_idx;
    logic [OWN_W-1:0] owner_q;
    logic [WD_W-1:0]  wd_q;

    logic load_grant;
    logic done_seen;
    logic wd_expired;

    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [FLOAT_W-1:0] rsp_data_q;
    logic               rsp_neg_q;
    logic               rsp_timeout_q;
    logic               sq_rst_q;
    logic               sq_start_q;
    logic [FLOAT_W-1:0] operand_q;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (cli.req),
        .upd_en  (state_q == ST_GRANT),
        .upd_idx (owner_q),
        .win_any (win_any),
        .win_idx (win_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; sq_done is only honoured in WAIT and beats the watchdog
    always_comb begin
        state_d    = state_q;
        load_grant = 1'b0;
        done_seen  = 1'b0;
        wd_expired = (wd_q == WD_LAST);
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d    = ST_GRANT;
                    load_grant = 1'b1;
                end
            end
            ST_GRANT: state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sq.sq_done) begin
                    done_seen = 1'b1;
                    state_d   = ST_RESP;
                end else if (wd_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Owner and operand capture; the operand is held until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= '0;
            operand_q <= '0;
        end else if (load_grant) begin
            owner_q   <= win_idx;
            operand_q <= cli.req_data[win_idx*FLOAT_W +: FLOAT_W];
        end
    end

    // Watchdog: cleared in START, counts every WAIT cycle without done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q == ST_START) begin
            wd_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Registered outputs, decoded from the state being entered so each
    // pulse lines up with its state; sq_rst stays high through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_neg_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            sq_rst_q      <= 1'b1;
            sq_start_q    <= 1'b0;
        end else begin
            gnt_q         <= load_grant ? (N_REQ'(1) << win_idx) : '0;
            rsp_valid_q   <= (state_d == ST_RESP || state_d == ST_ABORT)
                             ? (N_REQ'(1) << owner_q) : '0;
            rsp_data_q    <= (done_seen && !sq.sq_neg) ? sq.sq_result : '0;
            rsp_neg_q     <= done_seen && sq.sq_neg;
            rsp_timeout_q <= (state_d == ST_ABORT);
            sq_rst_q      <= (state_d == ST_ABORT);
            sq_start_q    <= (state_d == ST_START);
        end
    end

    assign cli.gnt         = gnt_q;
    assign cli.rsp_valid   = rsp_valid_q;
    assign cli.rsp_data    = rsp_data_q;
    assign cli.rsp_neg     = rsp_neg_q;
    assign cli.rsp_timeout = rsp_timeout_q;
    assign sq.sq_rst       = sq_rst_q;
    assign sq.sq_start     = sq_start_q;
    assign sq.sq_operand   = operand_q;

endmodule

// File: tb/tb_sqrt_cordic_rr_scheduler.sv
// Bench for sqrt_cordic_rr_scheduler: a behavioural sqrt unit stub plus a
// round-robin reference model predicting grant order and responses.
module tb_sqrt_cordic_rr_scheduler;
    import sqrt_sched_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int W   = FLOAT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sqrt_cordic_rr_scheduler_if #(.N_REQ(N), .FLOAT_W(W)) cli ();
    sqrt_unit_if #(.FLOAT_W(W)) sq ();

    sqrt_cordic_rr_scheduler #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cli   (cli),
        .sq    (sq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned m_ptr = 0;
    logic [W-1:0] data_q [N];

    // Stub unit controls
    bit          never_done = 1'b0;
    int unsigned lat        = 4;
    logic        stub_done  = 1'b0;
    logic        spur_done  = 1'b0;
    logic        stub_neg   = 1'b0;
    logic [W-1:0] stub_res  = '0;
    logic [W-1:0] stub_op   = '0;
    bit          busy       = 1'b0;
    int unsigned cnt        = 0;

    assign sq.sq_done   = stub_done | spur_done;
    assign sq.sq_neg    = stub_neg;
    assign sq.sq_result = stub_res;

    // Behaviour of the sqrt unit: exact roots for the directed operands,
    // an arbitrary nonzero tag otherwise
    function automatic logic [W-1:0] unit_fn(input logic [W-1:0] op);
        case (op)
            32'h4080_0000: return 32'h4000_0000;
            32'h4180_0000: return 32'h4080_0000;
            default:       return op ^ 32'h1357_9BDF;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_op();
        return W'($urandom);
    endfunction

    function automatic int pick(input logic [N-1:0] pend, input int unsigned p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'((p + k) % N);
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    // Stub unit: done arrives lat cycles after the start cycle
    always @(negedge clk) begin
        stub_done = 1'b0;
        if (sq.sq_rst) begin
            busy = 1'b0;
        end else if (busy) begin
            if (cnt == 0) begin
                stub_done = 1'b1;
                stub_res  = unit_fn(stub_op);
                stub_neg  = stub_op[W-1];
                busy      = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end else if (sq.sq_start && !never_done) begin
            busy    = 1'b1;
            cnt     = lat - 1;
            stub_op = sq.sq_operand;
        end
    end

    // Serve the requesters in mask with data_q; reraise re-requests each
    // served requester right after its grant
    task automatic serve(input logic [N-1:0] mask, input int n_grants,
                         input bit reraise, input bit expect_to);
        logic [N-1:0] pend;
        logic [W-1:0] op, exp_d;
        logic         exp_n;
        int           w, cyc, starts, exp_cyc;
        bit           seen;
        pend = mask;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                cli.req_data[i*W +: W] = data_q[i];
                cli.req[i] = 1'b1;
            end
        end
        for (int k = 0; k < n_grants; k++) begin
            w = pick(pend, m_ptr);
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (cli.gnt != '0) seen = 1'b1;
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL gnt_wait: no gnt within 20 cycles, expected requester %0d", w);
                cli.req = '0;
                return;
            end
            n_tests++;
            if (cli.gnt !== (N'(1) << w)) begin
                n_fail++;
                $display("FAIL gnt_order: got %b expected %b", cli.gnt, N'(1) << w);
            end
            op = data_q[w];
            cli.req[w] = 1'b0;
            m_ptr = (w + 1) % N;
            if (!reraise) pend[w] = 1'b0;
            starts = 0;
            cyc = 0;
            seen = 1'b0;
            for (int c = 0; c < TMO + 20 && !seen; c++) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) begin
                    n_tests++;
                    if (cli.gnt !== '0) begin
                        n_fail++;
                        $display("FAIL gnt_pulse: got %b expected 0", cli.gnt);
                    end
                    if (reraise) begin
                        data_q[w] = rand_op();
                        cli.req_data[w*W +: W] = data_q[w];
                        cli.req[w] = 1'b1;
                    end
                end
                if (sq.sq_start) starts++;
                if (cli.rsp_valid != '0) seen = 1'b1;
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL rsp_wait: no rsp_valid within %0d cycles", TMO + 20);
                cli.req = '0;
                return;
            end
            exp_d   = (expect_to || op[W-1]) ? '0 : unit_fn(op);
            exp_n   = expect_to ? 1'b0 : op[W-1];
            exp_cyc = expect_to ? TMO + 2 : int'(lat) + 2;
            n_tests++;
            if (cli.rsp_valid !== (N'(1) << w)) begin
                n_fail++;
                $display("FAIL rsp_owner: got %b expected %b", cli.rsp_valid, N'(1) << w);
            end
            n_tests++;
            if (cli.rsp_data !== exp_d) begin
                n_fail++;
                $display("FAIL rsp_data: op %h got %h expected %h", op, cli.rsp_data, exp_d);
            end
            n_tests++;
            if (cli.rsp_neg !== exp_n || cli.rsp_timeout !== expect_to) begin
                n_fail++;
                $display("FAIL rsp_flags: got neg %b to %b expected neg %b to %b",
                         cli.rsp_neg, cli.rsp_timeout, exp_n, expect_to);
            end
            n_tests++;
            if (sq.sq_rst !== expect_to) begin
                n_fail++;
                $display("FAIL sq_rst_abort: got %b expected %b", sq.sq_rst, expect_to);
            end
            n_tests++;
            if (sq.sq_operand !== op) begin
                n_fail++;
                $display("FAIL operand_hold: got %h expected %h", sq.sq_operand, op);
            end
            n_tests++;
            if (starts != 1) begin
                n_fail++;
                $display("FAIL start_pulses: got %0d expected 1", starts);
            end
            n_tests++;
            if (cyc != exp_cyc) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles expected %0d", cyc, exp_cyc);
            end
            if (reraise && k == n_grants - 1) cli.req = '0;
            @(negedge clk);
            n_tests++;
            if (cli.rsp_valid !== '0 || sq.sq_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_pulse: got rsp_valid %b sq_rst %b expected 0 0",
                         cli.rsp_valid, sq.sq_rst);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (cli.gnt !== '0 || cli.rsp_valid !== '0 || cli.rsp_data !== '0 ||
            cli.rsp_neg !== 1'b0 || cli.rsp_timeout !== 1'b0 || sq.sq_start !== 1'b0 ||
            sq.sq_operand !== '0 || sq.sq_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt %b rsp_valid %b data %h sq_start %b sq_rst %b expected 0 0 0 0 1",
                     cli.gnt, cli.rsp_valid, cli.rsp_data, sq.sq_start, sq.sq_rst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sq.sq_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: sq_rst got %b expected 0", sq.sq_rst);
        end
    endtask

    task automatic test_single();
        data_q[0] = 32'h4080_0000;
        lat = 5;
        serve(4'b0001, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        data_q[1] = rand_op() & 32'h7FFF_FFFF;
        data_q[2] = rand_op() & 32'h7FFF_FFFF;
        lat = 3;
        serve(4'b0110, 2, 1'b0, 1'b0);
    endtask

    task automatic test_negative();
        data_q[3] = 32'hC080_0000;
        data_q[0] = rand_op() & 32'h7FFF_FFFF;
        lat = 7;
        serve(4'b1001, 2, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        never_done = 1'b1;
        data_q[1] = rand_op() & 32'h7FFF_FFFF;
        serve(4'b0010, 1, 1'b0, 1'b1);
        never_done = 1'b0;
        data_q[2] = rand_op();
        lat = 2;
        serve(4'b0100, 1, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_done();
        bit bad;
        bad = 1'b0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (cli.rsp_valid !== '0 || cli.gnt !== '0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL spurious_done: got activity on rsp_valid/gnt expected none");
        end
        data_q[0] = rand_op();
        lat = 1;
        serve(4'b0001, 1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int  w;
        bit  seen, bad;
        w = pick(4'b0100, m_ptr);
        data_q[2] = rand_op() & 32'h7FFF_FFFF;
        lat = 40;
        cli.req_data[2*W +: W] = data_q[2];
        cli.req[2] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cli.gnt != '0) seen = 1'b1;
        end
        n_tests++;
        if (cli.gnt !== (N'(1) << w)) begin
            n_fail++;
            $display("FAIL mid_reset_gnt: got %b expected %b", cli.gnt, N'(1) << w);
        end
        cli.req[2] = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cli.gnt !== '0 || cli.rsp_valid !== '0 || cli.rsp_data !== '0 ||
            cli.rsp_neg !== 1'b0 || cli.rsp_timeout !== 1'b0 || sq.sq_start !== 1'b0 ||
            sq.sq_operand !== '0 || sq.sq_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rsp_valid %b operand %h sq_rst %b expected 0 0 1",
                     cli.rsp_valid, sq.sq_operand, sq.sq_rst);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cli.rsp_valid !== '0) bad = 1'b1;
        end
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (3) begin
            @(negedge clk);
            if (cli.rsp_valid !== '0 || sq.sq_rst !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got rsp_valid or sq_rst activity expected none");
        end
        data_q[3] = 32'h4180_0000;
        lat = 6;
        serve(4'b1000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_all_held();
        for (int i = 0; i < N; i++) data_q[i] = rand_op();
        lat = 2;
        serve(4'b1111, 5, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        for (int r = 0; r < 8; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) data_q[i] = rand_op();
            lat = $urandom_range(1, 12);
            serve(mask, $countones(mask), 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "simulation time limit");
    end

    initial begin
        cli.req      = '0;
        cli.req_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_negative();
        test_timeout();
        test_spurious_done();
        test_mid_reset();
        test_all_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
